// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// Results are presented with a one-cycle done pulse and held until the next one.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             overflow_q, overflow_d;

  logic [BW-1:0]    adj;
  logic             accept;

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign accept = start && (state_q != S_CONV);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d   = S_CONV;
          shift_d   = bin_in;
          scratch_d = '0;
          ovf_d     = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        // A bit leaving the top digit means the value no longer fits.
        scratch_d = {adj[BW-2:0], shift_q[BIN_W-1]};
        shift_d   = {shift_q[BIN_W-2:0], 1'b0};
        ovf_d     = ovf_q | adj[BW-1];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_DONE;
          bcd_d      = {adj[BW-2:0], shift_q[BIN_W-1]};
          overflow_d = ovf_q | adj[BW-1];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == S_CONV);
  assign done     = (state_q == S_DONE);
  assign bcd_out  = bcd_q;
  assign overflow = overflow_q;

endmodule
